// File: rtl/compress_offset_unit_mlane_pkg.sv
// Shared types and default sizing for the multi-lane vcompress offset unit.
package compress_offset_unit_mlane_pkg;

    localparam int COU_LANES_DEF = 4;
    localparam int COU_MAXVL_DEF = 32;

    typedef enum logic [1:0] {
        COU_IDLE = 2'd0,
        COU_SCAN = 2'd1,
        COU_DONE = 2'd2
    } cou_state_t;

endpackage

// File: rtl/compress_offset_unit_mlane_prefix_popcount.sv
// Exclusive prefix popcount per lane plus the total population count.
module prefix_popcount #(
    parameter int N = 4,
    parameter int W = $clog2(N) + 1
) (
    input  logic [N-1:0]        bits_i,
    output logic [N-1:0][W-1:0] pre_o,
    output logic [W-1:0]        total_o
);

    logic [W-1:0] acc;

    // Ripple accumulate; N is small so a linear chain is fine for timing.
    always_comb begin
        acc   = '0;
        pre_o = '0;
        for (int i = 0; i < N; i++) begin
            pre_o[i] = acc;
            acc      = acc + W'(bits_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/compress_offset_unit_mlane.sv
// Scans the vcompress source mask LANES elements per cycle and produces
// per-lane write enables and dense destination offsets plus the final count.
module compress_offset_unit_mlane
    import compress_offset_unit_mlane_pkg::*;
#(
    parameter int LANES = COU_LANES_DEF,
    parameter int MAXVL = COU_MAXVL_DEF,
    parameter int OFF_W = $clog2(MAXVL)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ena,
    input  logic [OFF_W:0]              vl,
    input  logic                        stall,
    input  logic [LANES-1:0]            mask_in,
    output logic [OFF_W-1:0]            elem_idx,
    output logic                        checking_mask,
    output logic [LANES-1:0]            wen,
    output logic [LANES-1:0][OFF_W-1:0] woffset,
    output logic                        busy,
    output logic                        done,
    output logic [OFF_W:0]              count
);

    localparam int PC_W = $clog2(LANES) + 1;

    cou_state_t state_q, state_d;
    logic [OFF_W-1:0] elem_idx_q, elem_idx_d;
    logic [OFF_W:0]   base_q, base_d;
    logic [OFF_W:0]   vl_q, vl_d;
    logic [OFF_W:0]   count_q, count_d;

    logic                       scan;
    logic [LANES-1:0]           valid;
    logic [LANES-1:0]           m;
    logic [LANES-1:0][PC_W-1:0] pre;
    logic [PC_W-1:0]            total;
    logic [OFF_W:0]             idx_ext;
    logic [OFF_W:0]             base_sum;
    logic                       last_grp;

    assign scan    = (state_q == COU_SCAN);
    assign idx_ext = {1'b0, elem_idx_q};

    // Tail lanes beyond vl are masked off so they neither write nor count.
    for (genvar i = 0; i < LANES; i++) begin : g_valid
        assign valid[i] = (idx_ext + (OFF_W+1)'(i)) < vl_q;
    end

    assign m = mask_in & valid & {LANES{scan}};

    prefix_popcount #(.N(LANES), .W(PC_W)) u_pc (
        .bits_i  (m),
        .pre_o   (pre),
        .total_o (total)
    );

    assign base_sum = base_q + (OFF_W+1)'(total);
    assign last_grp = (idx_ext + (OFF_W+1)'(LANES)) >= vl_q;

    for (genvar i = 0; i < LANES; i++) begin : g_off
        assign woffset[i] = scan ? OFF_W'(base_q + (OFF_W+1)'(pre[i])) : '0;
    end

    assign wen           = m;
    assign checking_mask = scan;
    assign elem_idx      = elem_idx_q;
    assign busy          = (state_q != COU_IDLE);
    assign done          = (state_q == COU_DONE);
    assign count         = count_q;

    always_comb begin
        state_d    = state_q;
        elem_idx_d = elem_idx_q;
        base_d     = base_q;
        vl_d       = vl_q;
        count_d    = count_q;
        case (state_q)
            COU_IDLE: begin
                if (ena) begin
                    count_d = '0;
                    if (vl != '0) begin
                        vl_d       = vl;
                        elem_idx_d = '0;
                        base_d     = '0;
                        state_d    = COU_SCAN;
                    end else begin
                        state_d = COU_DONE;
                    end
                end
            end
            COU_SCAN: begin
                if (!stall) begin
                    base_d     = base_sum;
                    elem_idx_d = elem_idx_q + OFF_W'(LANES);
                    if (last_grp) begin
                        count_d = base_sum;
                        state_d = COU_DONE;
                    end
                end
            end
            COU_DONE: state_d = COU_IDLE;
            default:  state_d = COU_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= COU_IDLE;
            elem_idx_q <= '0;
            base_q     <= '0;
            vl_q       <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            elem_idx_q <= elem_idx_d;
            base_q     <= base_d;
            vl_q       <= vl_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_compress_offset_unit_mlane.sv
// Directed bench for compress_offset_unit_mlane with LANES=4, MAXVL=32.
module tb_compress_offset_unit_mlane;

    localparam int LANES = 4;
    localparam int MAXVL = 32;
    localparam int OFF_W = 5;

    logic                        CLK = 1'b0;
    logic                        RST;
    logic                        ena;
    logic [OFF_W:0]              vl;
    logic                        stall;
    logic [LANES-1:0]            mask_in;
    logic [OFF_W-1:0]            elem_idx;
    logic                        checking_mask;
    logic [LANES-1:0]            wen;
    logic [LANES-1:0][OFF_W-1:0] woffset;
    logic                        busy;
    logic                        done;
    logic [OFF_W:0]              count;

    logic [31:0] mask_mem;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // Mask register file model: combinational read at elem_idx.
    assign mask_in = LANES'(mask_mem >> elem_idx);

    compress_offset_unit_mlane #(.LANES(LANES), .MAXVL(MAXVL), .OFF_W(OFF_W)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .ena           (ena),
        .vl            (vl),
        .stall         (stall),
        .mask_in       (mask_in),
        .elem_idx      (elem_idx),
        .checking_mask (checking_mask),
        .wen           (wen),
        .woffset       (woffset),
        .busy          (busy),
        .done          (done),
        .count         (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".wen"}, wen, 0);
        chk({tag, ".woff"}, woffset, 0);
        chk({tag, ".cm"}, checking_mask, 0);
    endtask

    initial begin
        RST = 1'b1; ena = 1'b0; vl = '0; stall = 1'b0; mask_mem = '0;
        #2;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.count", count, 0);
        chk("rst.idx", elem_idx, 0);
        chk_idle_outs("rst");
        tick();
        RST = 1'b0;
        tick();

        // vl=8, mask 1011_0110
        mask_mem = 32'hB6; vl = 7'd8; ena = 1'b1;
        tick(); ena = 1'b0;
        chk("t1g0.cm", checking_mask, 1);
        chk("t1g0.wen", wen, 4'b0110);
        chk("t1g0.off1", woffset[1], 0);
        chk("t1g0.off2", woffset[2], 1);
        chk("t1g0.off3", woffset[3], 2);
        chk("t1g0.busy", busy, 1);
        tick();
        chk("t1g1.idx", elem_idx, 4);
        chk("t1g1.wen", wen, 4'b1011);
        chk("t1g1.off0", woffset[0], 2);
        chk("t1g1.off1", woffset[1], 3);
        chk("t1g1.off3", woffset[3], 4);
        tick();
        chk("t1.done", done, 1);
        chk("t1.count", count, 5);
        chk_idle_outs("t1done");
        tick();
        chk("t1.done_pulse", done, 0);
        chk("t1.busy_after", busy, 0);
        chk("t1.count_held", count, 5);

        // vl=6, all ones: tail lanes masked in group 1
        mask_mem = 32'hFFFF_FFFF; vl = 7'd6; ena = 1'b1;
        tick(); ena = 1'b0;
        chk("t2g0.wen", wen, 4'b1111);
        chk("t2g0.off3", woffset[3], 3);
        tick();
        chk("t2g1.wen", wen, 4'b0011);
        chk("t2g1.off0", woffset[0], 4);
        chk("t2g1.off1", woffset[1], 5);
        tick();
        chk("t2.done", done, 1);
        chk("t2.count", count, 6);
        tick();

        // vl=0: straight to DONE
        vl = 7'd0; ena = 1'b1;
        tick(); ena = 1'b0;
        chk("t3.done", done, 1);
        chk("t3.count", count, 0);
        chk_idle_outs("t3");
        tick();
        chk("t3.done_pulse", done, 0);
        chk("t3.busy", busy, 0);
        chk_idle_outs("t3b");

        // vl=8, 0xFF, stall in first SCAN cycle
        mask_mem = 32'hFF; vl = 7'd8; ena = 1'b1;
        tick(); ena = 1'b0; stall = 1'b1;
        chk("t4a.wen", wen, 4'b1111);
        chk("t4a.off", woffset, {5'd3, 5'd2, 5'd1, 5'd0});
        tick(); stall = 1'b0;
        chk("t4b.idx", elem_idx, 0);
        chk("t4b.wen", wen, 4'b1111);
        chk("t4b.off", woffset, {5'd3, 5'd2, 5'd1, 5'd0});
        chk("t4b.done", done, 0);
        tick();
        chk("t4c.idx", elem_idx, 4);
        chk("t4c.off", woffset, {5'd7, 5'd6, 5'd5, 5'd4});
        tick();
        chk("t4.done", done, 1);
        chk("t4.count", count, 8);
        tick();

        // reset in group 1 of a vl=16 scan
        mask_mem = 32'hFFFF; vl = 7'd16; ena = 1'b1;
        tick(); ena = 1'b0;
        tick();
        chk("t5.g1wen", wen, 4'b1111);
        chk("t5.g1off0", woffset[0], 4);
        RST = 1'b1;
        #1;
        chk("t5.rst_busy", busy, 0);
        chk("t5.rst_idx", elem_idx, 0);
        chk("t5.rst_count", count, 0);
        chk_idle_outs("t5rst");
        tick(); RST = 1'b0;
        tick();
        chk("t5.nodone", done, 0);
        chk("t5.idle", busy, 0);
        tick();
        chk("t5.nodone2", done, 0);
        mask_mem = 32'h1; vl = 7'd4; ena = 1'b1;
        tick(); ena = 1'b0;
        chk("t5n.wen", wen, 4'b0001);
        chk("t5n.off0", woffset[0], 0);
        tick();
        chk("t5n.done", done, 1);
        chk("t5n.count", count, 1);
        tick();

        // vl=32, all zero, ena re-pulsed mid-scan
        mask_mem = 32'h0; vl = 7'd32; ena = 1'b1;
        tick(); ena = 1'b0;
        for (int g = 0; g < 8; g++) begin
            chk("t6.cm", checking_mask, 1);
            chk("t6.wen", wen, 0);
            chk("t6.idx", elem_idx, g * 4);
            chk("t6.done", done, 0);
            if (g == 3) begin
                ena = 1'b1; vl = 7'd4;
            end else begin
                ena = 1'b0;
            end
            tick();
        end
        ena = 1'b0;
        chk("t6.done_end", done, 1);
        chk("t6.count", count, 0);
        tick();
        chk("t6.after_done", done, 0);
        chk("t6.after_busy", busy, 0);
        tick();
        chk("t6.still_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/compress_offset_unit_mlane.md
# compress_offset_unit_mlane

Parametrised, multi-lane successor to the two-lane compress offset unit used by the vector `vcompress` path. Scans the source mask `LANES` elements per cycle and emits per-lane write enables plus dense destination offsets, i.e. each lane's exclusive prefix popcount plus a running base. Sits between the vector mask register read port and the vector register file write port. Supports a runtime `vl`, downstream stall and a final compressed-count result.

## Interface

Parameters:
- `LANES`, default 4, elements scanned per cycle; power of two, at least 2.
- `MAXVL`, default 32, maximum vector length; a multiple of `LANES`.
- `OFF_W`, default `$clog2(MAXVL)`, width of offsets and element indices.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `ena`  in  1  start pulse; sampled only in IDLE.
- `vl`  in  `OFF_W+1`  vector length; latched on accepted `ena`.
- `stall`  in  1  write port not accepting; hold the current group.
- `mask_in`  in  `LANES`  mask bits for elements `elem_idx .. elem_idx+LANES-1`; bit 0 is the lowest element; combinational return from the mask register file.
- `elem_idx`  out  `OFF_W`  first element of the group being checked.
- `checking_mask`  out  1  high in SCAN; `mask_in` is valid and consumed.
- `wen`  out  `LANES`  per-lane destination write enable.
- `woffset`  out  `LANES` x `OFF_W`  per-lane destination element offset.
- `busy`  out  1  high in SCAN and DONE.
- `done`  out  1  one-cycle pulse at completion.
- `count`  out  `OFF_W+1`  number of elements written; valid while `done` is high and held until the next accepted `ena`.

## Operation

- FSM `IDLE -> SCAN -> DONE -> IDLE`.
- IDLE, `ena=1`, `vl>0`:
  - latch `vl`;
  - clear `elem_idx` and `base`;
  - go to SCAN.
- IDLE, `ena=1`, `vl=0`: clear `count`; go to DONE.
- `ena` is ignored outside IDLE.
- SCAN, combinational:
  - `valid[i] = (elem_idx+i < vl_q)`;
  - `m[i] = mask_in[i] & valid[i]`;
  - `wen = m`;
  - `woffset[i] = base + popcount(m[i-1:0])`, computed even when `wen[i]=0`.
- SCAN, `stall=0`, on the edge:
  - `base += popcount(m)`;
  - `elem_idx += LANES`;
  - if `elem_idx+LANES >= vl_q`, go to DONE and set `count = base + popcount(m)`.
- SCAN, `stall=1`: state, `elem_idx` and `base` are held. The `wen`/`woffset` outputs stay stable provided `mask_in` is stable. `mask_in` must stay stable while `stall` is high.
- DONE: `done=1` for exactly one cycle, then IDLE. `stall` is ignored in DONE.
- Outputs in IDLE and DONE: `wen=0`, `woffset=0`, `checking_mask=0`.
- Arithmetic: offsets never exceed `MAXVL-1`. `base` and `count` are `OFF_W+1` bits, so `count=MAXVL` is representable.
- Reset, including mid-SCAN:
  - state IDLE;
  - `elem_idx`, `base`, `vl_q`, `count` = 0;
  - all outputs 0;
  - the aborted operation produces no `done`.

## Timing

- `ena` accepted at edge t; group 0 is presented in cycle t+1.
- With no stalls, SCAN lasts `ceil(vl/LANES)` cycles; `done` is high in the following cycle.
- Total latency from `ena` to `done` = `ceil(vl/LANES)+1` cycles, plus one cycle per stalled SCAN cycle. For `vl=0` it is 1 cycle.
- `ena` is accepted again in the cycle after `done`. Minimum back-to-back spacing is `ceil(vl/LANES)+2` cycles.
- No registered outputs in the `mask_in` to `wen`/`woffset` path. This is a single-cycle combinational prefix network.

## Structure

- Add to `rv32i_types_pkg`: `cou_state_t` (IDLE/SCAN/DONE) and the default `LANES`/`MAXVL` constants.
- Update `compress_offset_unit_if` to carry the parametrised port set.
- One sub-module: `prefix_popcount #(N, W)`. It produces an exclusive prefix popcount per lane plus a total, and is reused for `woffset` and the `base` update.

## Test plan

- `LANES=4`, `vl=8`, mask `0b1011_0110`:
  - t+1: `wen=0110`, `woffset[1]=0`, `woffset[2]=1`;
  - t+2: `wen=1011`, `woffset[0]=2`, `woffset[1]=3`, `woffset[3]=4`;
  - `done` at t+3 with `count=5`.
- `vl=6`, mask all ones: group 1 `wen=0011`, offsets 4 and 5 (lanes 2-3 masked by tail); `count=6`.
- `vl=0`: `done` at t+1, `count=0`, `wen` never asserted, `checking_mask` never high.
- `vl=8`, mask `0xFF`, `stall` high in the first SCAN cycle:
  - group 0 outputs held for 2 cycles with offsets 0..3;
  - group 1 offsets 4..7;
  - `done` at t+4, `count=8`.
- `RST` pulsed during group 1 of a `vl=16` scan:
  - all outputs 0 next cycle, no `done`;
  - a new `ena` with `vl=4` and mask `0001` yields `wen=0001`, `woffset[0]=0`, `count=1`.
- `vl=32`, mask all zero, `ena` re-pulsed mid-SCAN:
  - 8 SCAN cycles, `wen` always 0;
  - `done` at t+9, `count=0`;
  - the re-pulse has no effect.
